// File: rtl/rf_checkpoint_monitor.sv
// rf_checkpoint_monitor
//
// Snoops a CPU register-file write port and walks a programmed table of
// checkpoints. The program under test announces checkpoint N (1-based) by
// writing N to the flag register. The monitor then compares up to CHECKS
// register/value pairs for that step against its own shadow copy of the
// register file, and reports pass, mismatch, timeout or out-of-order flag.
//
// Optional build macro:
//   RF_MON_TRACE_EN - simulation-only $display per checkpoint result.
//                     Ports and timing are the same with or without it.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   rf_we/rf_waddr/rf_wdata  snooped register-file write port
//   cfg_we/cfg_step/cfg_slot table write: one slot per cycle, any state
//   cfg_valid/cfg_reg/cfg_val slot enable, register to check, expected value
//   start, num_steps         run request; num_steps sampled with start
//   busy, done, pass         run status (done sticky until start/rst)
//   fail_code                0 none, 1 mismatch, 2 timeout, 3 out-of-order
//   fail_step/reg/got/exp    failure detail (reg/got/exp for mismatch only)
//   cur_step                 step currently awaited
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | no run since reset
// S_WAIT_FLAG | waiting for flag write cur_step+1, timer running
// S_CHECK     | one cycle: compare valid slots of cur_step with shadow
// S_DONE      | result held until the next start
module rf_checkpoint_monitor #(
   parameter int XLEN           = 32,
   parameter int NUM_STEPS      = 16,
   parameter int CHECKS         = 4,
   parameter int TIMEOUT_CYCLES = 100,
   parameter int FLAG_REG       = 20
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           rf_we,
   input  logic [4:0]                     rf_waddr,
   input  logic [XLEN-1:0]                rf_wdata,
   input  logic                           cfg_we,
   input  logic [$clog2(NUM_STEPS)-1:0]   cfg_step,
   input  logic [$clog2(CHECKS)-1:0]      cfg_slot,
   input  logic                           cfg_valid,
   input  logic [4:0]                     cfg_reg,
   input  logic [XLEN-1:0]                cfg_val,
   input  logic                           start,
   input  logic [$clog2(NUM_STEPS):0]     num_steps,
   output logic                           busy,
   output logic                           done,
   output logic                           pass,
   output logic [1:0]                     fail_code,
   output logic [$clog2(NUM_STEPS)-1:0]   fail_step,
   output logic [4:0]                     fail_reg,
   output logic [XLEN-1:0]                fail_got,
   output logic [XLEN-1:0]                fail_exp,
   output logic [$clog2(NUM_STEPS)-1:0]   cur_step
);

   localparam int SW   = $clog2(NUM_STEPS);
   localparam int NSW  = SW + 1;
   localparam int TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_FLAG = 2'd1,
      S_CHECK     = 2'd2,
      S_DONE      = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [XLEN-1:0]   shadow_q [32];
   logic [XLEN-1:0]   shadow_d [32];
   logic              tbl_valid_q [NUM_STEPS][CHECKS];
   logic              tbl_valid_d [NUM_STEPS][CHECKS];
   logic [4:0]        tbl_reg_q   [NUM_STEPS][CHECKS];
   logic [4:0]        tbl_reg_d   [NUM_STEPS][CHECKS];
   logic [XLEN-1:0]   tbl_val_q   [NUM_STEPS][CHECKS];
   logic [XLEN-1:0]   tbl_val_d   [NUM_STEPS][CHECKS];

   logic [SW-1:0]     cur_step_q, cur_step_d;
   logic [SW-1:0]     last_step_q, last_step_d;
   logic [TW-1:0]     tmr_q, tmr_d;
   logic              pass_q, pass_d;
   logic [1:0]        fail_code_q, fail_code_d;
   logic [SW-1:0]     fail_step_q, fail_step_d;
   logic [4:0]        fail_reg_q, fail_reg_d;
   logic [XLEN-1:0]   fail_got_q, fail_got_d;
   logic [XLEN-1:0]   fail_exp_q, fail_exp_d;

   logic              flag_wr;
   logic [XLEN-1:0]   flag_exp;
   logic [NSW-1:0]    num_clamped;
   logic              mis_found;
   logic [4:0]        mis_reg;
   logic [XLEN-1:0]   mis_got;
   logic [XLEN-1:0]   mis_exp;

   // Shadow register file and checkpoint table. x0 is never written, so it
   // keeps reading 0 from reset.
   always_comb begin
      shadow_d    = shadow_q;
      tbl_valid_d = tbl_valid_q;
      tbl_reg_d   = tbl_reg_q;
      tbl_val_d   = tbl_val_q;
      if (rf_we && (rf_waddr != 5'd0)) begin
         shadow_d[rf_waddr] = rf_wdata;
      end
      if (cfg_we && (int'(cfg_step) < NUM_STEPS) && (int'(cfg_slot) < CHECKS)) begin
         tbl_valid_d[cfg_step][cfg_slot] = cfg_valid;
         tbl_reg_d[cfg_step][cfg_slot]   = cfg_reg;
         tbl_val_d[cfg_step][cfg_slot]   = cfg_val;
      end
   end

   // Scanning from the top slot down lets the lowest mismatching slot win.
   always_comb begin
      mis_found = 1'b0;
      mis_reg   = '0;
      mis_got   = '0;
      mis_exp   = '0;
      for (int s = CHECKS - 1; s >= 0; s--) begin
         if (tbl_valid_q[cur_step_q][s] &&
             (shadow_q[tbl_reg_q[cur_step_q][s]] != tbl_val_q[cur_step_q][s])) begin
            mis_found = 1'b1;
            mis_reg   = tbl_reg_q[cur_step_q][s];
            mis_got   = shadow_q[tbl_reg_q[cur_step_q][s]];
            mis_exp   = tbl_val_q[cur_step_q][s];
         end
      end
   end

   assign flag_wr     = rf_we && (rf_waddr == 5'(FLAG_REG));
   assign flag_exp    = XLEN'(cur_step_q) + XLEN'(1);
   assign num_clamped = (num_steps > NSW'(NUM_STEPS)) ? NSW'(NUM_STEPS) : num_steps;

   // The timer counts down from TIMEOUT_CYCLES-1; expiring at 0 is the same
   // cycle an up-counter from 0 would reach TIMEOUT_CYCLES-1.
   always_comb begin
      state_d     = state_q;
      cur_step_d  = cur_step_q;
      last_step_d = last_step_q;
      tmr_d       = tmr_q;
      pass_d      = pass_q;
      fail_code_d = fail_code_q;
      fail_step_d = fail_step_q;
      fail_reg_d  = fail_reg_q;
      fail_got_d  = fail_got_q;
      fail_exp_d  = fail_exp_q;
      case (state_q)
         S_IDLE, S_DONE: begin
            if (start) begin
               cur_step_d  = '0;
               last_step_d = SW'(num_clamped - NSW'(1));
               tmr_d       = TW'(TIMEOUT_CYCLES - 1);
               pass_d      = 1'b0;
               fail_code_d = 2'd0;
               fail_step_d = '0;
               fail_reg_d  = '0;
               fail_got_d  = '0;
               fail_exp_d  = '0;
               if (num_steps == '0) begin
                  state_d = S_DONE;
                  pass_d  = 1'b1;
               end else begin
                  state_d = S_WAIT_FLAG;
               end
            end
         end
         S_WAIT_FLAG: begin
            if (flag_wr && (rf_wdata == flag_exp)) begin
               state_d = S_CHECK;
            end else if (flag_wr && (rf_wdata > flag_exp)) begin
               state_d     = S_DONE;
               fail_code_d = 2'd3;
               fail_step_d = cur_step_q;
            end else if (tmr_q == '0) begin
               state_d     = S_DONE;
               fail_code_d = 2'd2;
               fail_step_d = cur_step_q;
            end else begin
               tmr_d = tmr_q - TW'(1);
            end
         end
         S_CHECK: begin
            if (mis_found) begin
               state_d     = S_DONE;
               fail_code_d = 2'd1;
               fail_step_d = cur_step_q;
               fail_reg_d  = mis_reg;
               fail_got_d  = mis_got;
               fail_exp_d  = mis_exp;
            end else if (cur_step_q == last_step_q) begin
               state_d = S_DONE;
               pass_d  = 1'b1;
            end else begin
               state_d    = S_WAIT_FLAG;
               cur_step_d = cur_step_q + SW'(1);
               tmr_d      = TW'(TIMEOUT_CYCLES - 1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shadow_q    <= '{default: '0};
         tbl_valid_q <= '{default: '0};
         tbl_reg_q   <= '{default: '0};
         tbl_val_q   <= '{default: '0};
         cur_step_q  <= '0;
         last_step_q <= '0;
         tmr_q       <= '0;
         pass_q      <= 1'b0;
         fail_code_q <= 2'd0;
         fail_step_q <= '0;
         fail_reg_q  <= '0;
         fail_got_q  <= '0;
         fail_exp_q  <= '0;
      end else begin
         state_q     <= state_d;
         shadow_q    <= shadow_d;
         tbl_valid_q <= tbl_valid_d;
         tbl_reg_q   <= tbl_reg_d;
         tbl_val_q   <= tbl_val_d;
         cur_step_q  <= cur_step_d;
         last_step_q <= last_step_d;
         tmr_q       <= tmr_d;
         pass_q      <= pass_d;
         fail_code_q <= fail_code_d;
         fail_step_q <= fail_step_d;
         fail_reg_q  <= fail_reg_d;
         fail_got_q  <= fail_got_d;
         fail_exp_q  <= fail_exp_d;
      end
   end

`ifdef RF_MON_TRACE_EN
   // Fires on the edge that advances the step or enters DONE.
   always @(posedge clk) begin
      if (!rst) begin
         if ((state_q == S_CHECK) && !mis_found) begin
            $display("PASS step %0d", cur_step_q);
         end else if ((state_q != S_DONE) && (state_d == S_DONE) && (fail_code_d != 2'd0)) begin
            $display("checkpoint fail code=%0d step=%0d reg=x%0d got=%0h expected=%0h",
                     fail_code_d, fail_step_d, fail_reg_d, fail_got_d, fail_exp_d);
         end
      end
   end
`else
   // No trace output in this build.
`endif

   assign busy      = (state_q == S_WAIT_FLAG) || (state_q == S_CHECK);
   assign done      = (state_q == S_DONE);
   assign pass      = pass_q;
   assign fail_code = fail_code_q;
   assign fail_step = fail_step_q;
   assign fail_reg  = fail_reg_q;
   assign fail_got  = fail_got_q;
   assign fail_exp  = fail_exp_q;
   assign cur_step  = cur_step_q;

endmodule

// File: tb/tb_rf_checkpoint_monitor.sv
module tb_rf_checkpoint_monitor;
   localparam int XLEN      = 32;
   localparam int NUM_STEPS = 16;
   localparam int CHECKS    = 4;
   localparam int TIMEOUT   = 100;
   localparam int FLAG_REG  = 20;
   localparam int SW        = $clog2(NUM_STEPS);
   localparam int CW        = $clog2(CHECKS);

   logic            clk = 1'b0;
   logic            rst;
   logic            rf_we;
   logic [4:0]      rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic            cfg_we;
   logic [SW-1:0]   cfg_step;
   logic [CW-1:0]   cfg_slot;
   logic            cfg_valid;
   logic [4:0]      cfg_reg;
   logic [XLEN-1:0] cfg_val;
   logic            start;
   logic [SW:0]     num_steps;
   logic            busy, done, pass;
   logic [1:0]      fail_code;
   logic [SW-1:0]   fail_step;
   logic [4:0]      fail_reg;
   logic [XLEN-1:0] fail_got, fail_exp;
   logic [SW-1:0]   cur_step;

   always #5 clk = ~clk;

   rf_checkpoint_monitor #(
      .XLEN(XLEN), .NUM_STEPS(NUM_STEPS), .CHECKS(CHECKS),
      .TIMEOUT_CYCLES(TIMEOUT), .FLAG_REG(FLAG_REG)
   ) dut (
      .clk(clk), .rst(rst),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .cfg_we(cfg_we), .cfg_step(cfg_step), .cfg_slot(cfg_slot),
      .cfg_valid(cfg_valid), .cfg_reg(cfg_reg), .cfg_val(cfg_val),
      .start(start), .num_steps(num_steps),
      .busy(busy), .done(done), .pass(pass), .fail_code(fail_code),
      .fail_step(fail_step), .fail_reg(fail_reg), .fail_got(fail_got),
      .fail_exp(fail_exp), .cur_step(cur_step)
   );

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: register contents and checkpoint table as plain arrays.
   logic [XLEN-1:0] m_shadow [32];
   logic            m_valid  [NUM_STEPS][CHECKS];
   logic [4:0]      m_reg    [NUM_STEPS][CHECKS];
   logic [XLEN-1:0] m_val    [NUM_STEPS][CHECKS];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 32; i++) m_shadow[i] = '0;
      for (int s = 0; s < NUM_STEPS; s++)
         for (int c = 0; c < CHECKS; c++) begin
            m_valid[s][c] = 1'b0;
            m_reg[s][c]   = '0;
            m_val[s][c]   = '0;
         end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      model_clear();
   endtask

   task automatic rf_wr(input int a, input logic [XLEN-1:0] d);
      rf_we = 1'b1; rf_waddr = 5'(a); rf_wdata = d;
      tick();
      rf_we = 1'b0;
      if (a != 0) m_shadow[a] = d;
   endtask

   task automatic cfg_wr(input int st, input int sl, input logic v, input int r, input logic [XLEN-1:0] val);
      cfg_we = 1'b1; cfg_step = SW'(st); cfg_slot = CW'(sl);
      cfg_valid = v; cfg_reg = 5'(r); cfg_val = val;
      tick();
      cfg_we = 1'b0;
      m_valid[st][sl] = v; m_reg[st][sl] = 5'(r); m_val[st][sl] = val;
   endtask

   task automatic start_run(input int n);
      start = 1'b1; num_steps = (SW+1)'(n);
      tick();
      start = 1'b0;
   endtask

   // Lowest valid slot of a step whose register differs from the model; -1 if none.
   function automatic int first_mis(input int st);
      for (int c = 0; c < CHECKS; c++)
         if (m_valid[st][c] && (m_shadow[m_reg[st][c]] !== m_val[st][c])) return c;
      return -1;
   endfunction

   task automatic random_run(input int nsteps);
      int ms;
      logic [XLEN-1:0] before_write [32];
      do_reset();
      for (int s = 0; s < nsteps; s++)
         for (int c = 0; c < CHECKS; c++)
            if ($urandom_range(0, 1) == 1)
               cfg_wr(s, c, 1'b1, $urandom_range(0, 6), $urandom_range(0, 3));
      start_run(nsteps);
      for (int k = 0; k < nsteps; k++) begin
         for (int w = $urandom_range(0, 4); w > 0; w--)
            rf_wr($urandom_range(0, 6), $urandom_range(0, 3));
         if ($urandom_range(0, 3) == 0) rf_wr(FLAG_REG, $urandom_range(0, k));
         rf_wr(FLAG_REG, k + 1);
         chk("rnd_check_busy", busy, 1);
         chk("rnd_check_done", done, 0);
         ms = first_mis(k);
         before_write = m_shadow;
         // A write landing during the check cycle must not affect the result.
         if ($urandom_range(0, 2) == 0) rf_wr($urandom_range(1, 6), $urandom_range(0, 3));
         else tick();
         if (ms >= 0) begin
            chk("rnd_fail_done", done, 1);
            chk("rnd_fail_code", fail_code, 1);
            chk("rnd_fail_step", fail_step, k);
            chk("rnd_fail_reg", fail_reg, m_reg[k][ms]);
            chk("rnd_fail_got", fail_got, before_write[m_reg[k][ms]]);
            chk("rnd_fail_exp", fail_exp, m_val[k][ms]);
            chk("rnd_fail_pass", pass, 0);
            return;
         end else if (k == nsteps - 1) begin
            chk("rnd_pass_done", done, 1);
            chk("rnd_pass_pass", pass, 1);
            chk("rnd_pass_code", fail_code, 0);
            chk("rnd_pass_step", cur_step, k);
         end else begin
            chk("rnd_adv_busy", busy, 1);
            chk("rnd_adv_step", cur_step, k + 1);
         end
      end
   endtask

   initial begin
      int cycles;
      rst = 1'b1; rf_we = 1'b0; rf_waddr = '0; rf_wdata = '0;
      cfg_we = 1'b0; cfg_step = '0; cfg_slot = '0; cfg_valid = 1'b0;
      cfg_reg = '0; cfg_val = '0; start = 1'b0; num_steps = '0;
      do_reset();

      // reset state
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_code", fail_code, 0);
      chk("rst_step", cur_step, 0);
      chk("rst_fstep", fail_step, 0);

      // single step pass, result two cycles after flag write
      cfg_wr(0, 0, 1'b1, 1, 300);
      start_run(1);
      rf_wr(1, 300);
      rf_wr(FLAG_REG, 1);
      chk("tp1_mid_done", done, 0);
      tick();
      chk("tp1_done", done, 1);
      chk("tp1_pass", pass, 1);
      chk("tp1_busy", busy, 0);

      // num_steps=0 from DONE: immediate pass
      start_run(0);
      chk("zero_done", done, 1);
      chk("zero_pass", pass, 1);

      // two steps pass
      do_reset();
      cfg_wr(0, 0, 1'b1, 1, 300);
      cfg_wr(1, 0, 1'b1, 1, 500);
      cfg_wr(1, 1, 1'b1, 2, 100);
      start_run(2);
      rf_wr(1, 300);
      rf_wr(FLAG_REG, 1);
      tick();
      chk("tp2_mid_step", cur_step, 1);
      rf_wr(1, 500);
      rf_wr(2, 100);
      rf_wr(FLAG_REG, 2);
      tick();
      chk("tp2_done", done, 1);
      chk("tp2_pass", pass, 1);
      chk("tp2_step", cur_step, 1);

      // mismatch
      do_reset();
      cfg_wr(0, 0, 1'b1, 1, 300);
      start_run(1);
      rf_wr(1, 299);
      rf_wr(FLAG_REG, 1);
      tick();
      chk("mis_code", fail_code, 1);
      chk("mis_step", fail_step, 0);
      chk("mis_reg", fail_reg, 1);
      chk("mis_got", fail_got, 299);
      chk("mis_exp", fail_exp, 300);
      chk("mis_pass", pass, 0);

      // timeout: done exactly TIMEOUT cycles after leaving IDLE
      do_reset();
      start_run(1);
      cycles = 0;
      while (!done && cycles < 3 * TIMEOUT) begin
         tick();
         cycles++;
      end
      chk("to_cycles", cycles, TIMEOUT);
      chk("to_code", fail_code, 2);
      chk("to_step", fail_step, 0);

      // out-of-order flag
      do_reset();
      start_run(2);
      rf_wr(FLAG_REG, 3);
      chk("ooo_done", done, 1);
      chk("ooo_code", fail_code, 3);
      chk("ooo_step", fail_step, 0);

      // stale flag value ignored
      do_reset();
      cfg_wr(0, 0, 1'b1, 1, 300);
      start_run(1);
      rf_wr(FLAG_REG, 0);
      chk("ign_busy", busy, 1);
      chk("ign_done", done, 0);
      rf_wr(1, 300);
      rf_wr(FLAG_REG, 1);
      tick();
      chk("ign_pass", pass, 1);
      chk("ign_code", fail_code, 0);

      // reset mid-run clears shadow and table
      do_reset();
      cfg_wr(0, 1, 1'b1, 2, 77);
      rf_wr(1, 300);
      start_run(1);
      chk("rstmid_busy_before", busy, 1);
      do_reset();
      chk("rstmid_busy", busy, 0);
      chk("rstmid_done", done, 0);
      cfg_wr(0, 0, 1'b1, 1, 0);
      start_run(1);
      rf_wr(FLAG_REG, 1);
      tick();
      chk("rstmid_pass", pass, 1);
      chk("rstmid_code", fail_code, 0);

      // num_steps clamped to NUM_STEPS
      do_reset();
      start_run(31);
      for (int k = 0; k < NUM_STEPS; k++) begin
         rf_wr(FLAG_REG, k + 1);
         tick();
      end
      chk("clamp_done", done, 1);
      chk("clamp_pass", pass, 1);
      chk("clamp_step", cur_step, NUM_STEPS - 1);

      // randomized runs against the model
      for (int r = 0; r < 24; r++) random_run($urandom_range(1, 6));

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
